// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: execute-stage multiply/divide bus between the pipeline (master) and multdiv_ctrl (slave)
// instruction/operandA/operandB/flush: X-stage inputs; stall/busy/result/result_valid/exception: controller outputs
interface multdiv_ctrl_if #(parameter int WIDTH = 32);
  logic [31:0] instruction;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic flush;
  logic stall;
  logic busy;
  logic [WIDTH-1:0] result;
  logic result_valid;
  logic exception;
  modport master(output instruction, operandA, operandB, flush, input stall, busy, result, result_valid, exception);
  modport slave(input instruction, operandA, operandB, flush, output stall, busy, result, result_valid, exception);
endinterface

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: iterative signed mul/div sequencer that stalls the pipeline until the result is ready
// clk/reset (async, active-high); bus: X-stage instruction and operands in, stall/busy/result/result_valid/exception out
module multdiv_ctrl #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  multdiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, prod_s;
  logic [WIDTH-1:0] a_mag, b_mag, q_s;
  logic [WIDTH:0] trial;
  logic [CW-1:0] idx;
  logic is_div, sign, div_ovf, dec, start, div0;
  assign dec = bus.instruction[31:27] == 5'b0 && bus.instruction[6:3] == 4'b0011;
  // start is gated by reset so stall drops the moment reset is applied
  assign start = !reset && state == IDLE && dec && !bus.flush;
  assign div0 = start && bus.instruction[2] && bus.operandB == '0;
  assign bus.stall = start || state == RUN;
  assign idx = cnt[CW-1:0];
  // restoring division consumes dividend bits MSB first; ~idx == WIDTH-1-cnt
  assign trial = {acc[2*WIDTH-1:WIDTH], a_mag[~idx]} - {1'b0, b_mag};
  assign acc_nx = is_div
    ? {trial[WIDTH] ? {acc[2*WIDTH-2:WIDTH], a_mag[~idx]} : trial[WIDTH-1:0], acc[WIDTH-2:0], ~trial[WIDTH]}
    : acc + (b_mag[idx] ? {{WIDTH{1'b0}}, a_mag} << idx : '0);
  assign prod_s = sign ? -acc_nx : acc_nx;
  assign q_s = sign ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      a_mag <= '0;
      b_mag <= '0;
      is_div <= 1'b0;
      sign <= 1'b0;
      div_ovf <= 1'b0;
      bus.busy <= 1'b0;
      bus.result <= '0;
      bus.result_valid <= 1'b0;
      bus.exception <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      bus.exception <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_mag <= bus.operandA[WIDTH-1] ? -bus.operandA : bus.operandA;
          b_mag <= bus.operandB[WIDTH-1] ? -bus.operandB : bus.operandB;
          is_div <= bus.instruction[2];
          sign <= bus.operandA[WIDTH-1] ^ bus.operandB[WIDTH-1];
          div_ovf <= bus.operandA == {1'b1, {(WIDTH-1){1'b0}}} && &bus.operandB;
          acc <= '0;
          cnt <= '0;
          if (div0) begin
            state <= DONE;
            bus.result <= '0;
            bus.result_valid <= 1'b1;
            bus.exception <= 1'b1;
          end else begin
            state <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: if (bus.flush) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          acc <= acc_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH-1)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.result_valid <= 1'b1;
            bus.result <= is_div ? q_s : prod_s[WIDTH-1:0];
            bus.exception <= is_div ? div_ovf : prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
